// File: rtl/conveng_mem_pkg.sv
// Shared types and sizing helpers for the convolution-engine memory read path.
package conveng_mem_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} rd_state_t;

  localparam int DEFAULT_ADDRW = 10;
  localparam int DEFAULT_DEPTH = 2 ** DEFAULT_ADDRW;

  function automatic int mem_depth(input int addrw);
    return 2 ** addrw;
  endfunction

endpackage

// File: rtl/mem_rd_stream.sv
// Walks a contiguous address range of a combinational-read memory and presents
// each word as a registered valid/ready beat, flagging the final beat.
module mem_rd_stream
  import conveng_mem_pkg::*;
#(
  parameter int ADDRW = 10,
  parameter int DATAW = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [ADDRW-1:0] base_addr,
  input  logic [ADDRW:0]   len,
  output logic             busy,
  output logic             done,
  output logic [ADDRW-1:0] mem_rd_addr,
  output logic             mem_rd_en,
  input  logic [DATAW-1:0] mem_rd_data,
  output logic             out_valid,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready
);

  localparam int REMW = ADDRW + 1;

  rd_state_t        state, state_nxt;
  logic [ADDRW-1:0] addr_q;
  logic [REMW-1:0]  rem_q;
  logic             load;
  logic             accept;

  // A new word is fetched whenever words remain and the output slot is free
  // or being drained this cycle, giving one beat per cycle under no stall.
  assign accept      = out_valid && out_ready;
  assign load        = (state == STREAM) && (rem_q != '0) && (!out_valid || out_ready);
  assign mem_rd_addr = addr_q;
  assign mem_rd_en   = load;
  assign busy        = (state == STREAM);
  assign done        = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) state_nxt = (len != '0) ? STREAM : DONE;
      end
      STREAM: begin
        if (accept && out_last) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output register and address/remaining counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      rem_q     <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      if (state == IDLE && start && len != '0) begin
        addr_q <= base_addr;
        rem_q  <= len;
      end
      if (load) begin
        out_data  <= mem_rd_data;
        out_valid <= 1'b1;
        out_last  <= (rem_q == REMW'(1));
        addr_q    <= addr_q + ADDRW'(1);
        rem_q     <= rem_q - REMW'(1);
      end else if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end

endmodule
